// File: rtl/lockstep_mismatch_monitor.sv
// lockstep_mismatch_monitor: warm-up masked mismatch counter with first-error timestamp and sticky fault
// Consumes the delayed-compare equal flag and declares a fault after THRESH consecutive mismatches.
module lockstep_mismatch_monitor #(
    parameter int WARMUP = 3,
    parameter int THRESH = 4,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             enable,
    input  logic             equal,
    input  logic             clear,
    output logic             fault,
    output logic             mismatch_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             first_valid,
    output logic [TS_W-1:0]  first_ts,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WARM, CHECK, FAULT} state_t;

    state_t          state, state_nx;
    logic [7:0]      warm_cnt, consec;
    logic [TS_W-1:0] ts;
    logic            sample, miss;

    // A sample is only taken while checking stays enabled and no clear discards it
    assign sample = (state == CHECK) && enable && !clear;
    assign miss   = sample && !equal;
    assign fault  = (state == FAULT);
    assign busy   = (state == WARM) || (state == CHECK);

    always_comb begin
        state_nx = state;
        if (clear) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    if (enable) state_nx = (WARMUP == 0) ? CHECK : WARM;
                WARM:    state_nx = !enable ? IDLE : (warm_cnt == 8'(WARMUP - 1)) ? CHECK : WARM;
                CHECK:   state_nx = !enable ? IDLE : (miss && consec == 8'(THRESH - 1)) ? FAULT : CHECK;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state          <= IDLE;
            warm_cnt       <= '0;
            consec         <= '0;
            ts             <= '0;
            mismatch_pulse <= 1'b0;
            err_count      <= '0;
            first_valid    <= 1'b0;
            first_ts       <= '0;
        end else begin
            state          <= state_nx;
            mismatch_pulse <= miss;
            if (clear) begin
                warm_cnt    <= '0;
                consec      <= '0;
                ts          <= '0;
                err_count   <= '0;
                first_valid <= 1'b0;
                first_ts    <= '0;
            end else begin
                warm_cnt <= (state == WARM) ? warm_cnt + 8'd1 : '0;
                if (state == IDLE || (state == CHECK && !enable)) begin
                    consec <= '0;
                    ts     <= '0;
                end else if (sample) begin
                    consec <= equal ? '0 : consec + 8'd1;
                    ts     <= &ts ? ts : ts + 1'b1;
                end
                if (miss) begin
                    err_count <= &err_count ? err_count : err_count + 1'b1;
                    if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_ts    <= ts;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lockstep_mismatch_monitor.sv
// tb_lockstep_mismatch_monitor: directed vectors with hand-computed expectations
// A second instance with CNT_W=2 shares the stimulus to exercise err_count saturation.
module tb_lockstep_mismatch_monitor;
    logic        clk = 1'b0, rst_l = 1'b0, enable = 1'b0, equal = 1'b1, clear = 1'b0;
    logic        fault, pulse, fvalid, busy;
    logic [15:0] err;
    logic [31:0] fts;
    logic        fault_s, pulse_s, fvalid_s, busy_s;
    logic [1:0]  err_s;
    logic [31:0] fts_s;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    lockstep_mismatch_monitor dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .equal(equal), .clear(clear),
        .fault(fault), .mismatch_pulse(pulse), .err_count(err),
        .first_valid(fvalid), .first_ts(fts), .busy(busy)
    );

    lockstep_mismatch_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_l(rst_l), .enable(enable), .equal(equal), .clear(clear),
        .fault(fault_s), .mismatch_pulse(pulse_s), .err_count(err_s),
        .first_valid(fvalid_s), .first_ts(fts_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {fault, busy, pulse, first_valid}
    function automatic logic [31:0] flags();
        return {28'd0, fault, busy, pulse, fvalid};
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        enable = 1'b0;
        tick();
        clear = 1'b0;
        chk("clear_flags", flags(), 32'h0);
        chk("clear_err", err, 0);
    endtask

    task automatic start_check();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("warm_busy", busy, 1);
            tick();
        end
        chk("check_busy", busy, 1);
    endtask

    initial begin
        // reset and idle
        #12;
        chk("rst_flags", flags(), 32'h0);
        chk("rst_err", err, 0);
        chk("rst_fts", fts, 0);
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 20; i++) begin
            equal = i[0];
            tick();
            chk("idle_flags", flags(), 32'h0);
            chk("idle_err", err, 0);
        end

        // warm-up mask: equal low during WARM must be ignored
        enable = 1'b1;
        equal = 1'b0;
        tick();
        chk("warm_enter_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("warm_pulse", pulse, 0);
            chk("warm_err", err, 0);
            chk("warm_busy2", busy, 1);
        end
        equal = 1'b1;

        // isolated mismatches at timestamps 5 and 9
        for (int t = 0; t < 12; t++) begin
            equal = !(t == 5 || t == 9);
            tick();
            chk("iso_pulse", pulse, (t == 5 || t == 9) ? 1 : 0);
            if (t == 5) chk("iso_first", {fvalid, fts[30:0]}, {1'b1, 31'd5});
        end
        equal = 1'b1;
        chk("iso_err", err, 2);
        chk("iso_fts", fts, 5);
        chk("iso_fvalid", fvalid, 1);
        chk("iso_fault", fault, 0);

        // fault run starting at timestamp 2
        do_clear();
        start_check();
        for (int t = 0; t < 6; t++) begin
            equal = (t < 2);
            tick();
            if (t == 4) chk("run_nofault", fault, 0);
        end
        chk("run_fault", fault, 1);
        chk("run_busy", busy, 0);
        chk("run_pulse", pulse, 1);
        chk("run_err", err, 4);
        chk("run_fts", fts, 2);
        for (int i = 0; i < 10; i++) begin
            enable = i[0];
            tick();
            chk("frozen_flags", flags(), 32'h9);
            chk("frozen_err", err, 4);
            chk("frozen_fts", fts, 2);
        end

        // clear in FAULT with enable held high
        enable = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("restart_idle_flags", flags(), 32'h0);
        chk("restart_idle_err", err, 0);
        chk("restart_idle_fts", fts, 0);
        tick();
        chk("restart_warm", busy, 1);
        equal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_mask", pulse, 0);
        end
        tick();
        equal = 1'b1;
        chk("restart_pulse", pulse, 1);
        chk("restart_fvalid", fvalid, 1);
        chk("restart_fts0", fts, 0);
        chk("restart_err", err, 1);

        // saturation of a 2-bit err_count, then async reset mid-CHECK
        do_clear();
        start_check();
        for (int k = 1; k <= 6; k++) begin
            equal = 1'b0;
            tick();
            chk("sat_pulse", pulse_s, 1);
            chk("sat_err", err_s, (k > 3) ? 3 : k);
            chk("wide_err", err, k);
            equal = 1'b1;
            tick();
            chk("sat_fault", fault_s, 0);
        end
        chk("sat_busy", busy_s, 1);
        tick();
        rst_l = 1'b0;
        #2;
        chk("arst_flags", flags(), 32'h0);
        chk("arst_err", err, 0);
        chk("arst_fts", fts, 0);
        chk("arst_s", {fault_s, busy_s, pulse_s, fvalid_s, err_s}, 0);
        #2;
        rst_l = 1'b1;
        chk("arst_hold", busy, 0);
        tick();
        chk("arst_rewarm", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lockstep_mismatch_monitor.md
# lockstep_mismatch_monitor

Downstream consumer of the delayed-compare `equal` flag. It sequences an enable/warm-up window that masks the comparator's unfilled delay line after start-up. It counts mismatches and timestamps the first one. It raises a sticky `fault` once a programmable run of consecutive mismatches is seen, and holds it until software clears it.

## Interface
- `WARMUP`, 3: cycles after enable during which `equal` is ignored; matches the comparator delay depth; legal 0..255.
- `THRESH`, 4: consecutive sampled mismatches that declare a fault; legal 1..255.
- `CNT_W`, 16: width of `err_count`.
- `TS_W`, 32: width of the check-window timestamp and `first_ts`.

- `clk`, in, 1: single clock, all state updates on rising edge.
- `rst_l`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level; high requests checking.
- `equal`, in, 1: compare result from the comparator stage, sampled only in CHECK.
- `clear`, in, 1: synchronous clear of all status; priority over everything but reset.
- `fault`, out, 1: sticky fault, high while in FAULT.
- `mismatch_pulse`, out, 1: one-cycle pulse per sampled mismatch.
- `err_count`, out, CNT_W: total sampled mismatches, saturating.
- `first_valid`, out, 1: `first_ts` holds a captured value.
- `first_ts`, out, TS_W: timestamp of first sampled mismatch.
- `busy`, out, 1: high in WARM or CHECK.

## Operation
- Reset values (all outputs and state): state=IDLE, `fault`=0, `mismatch_pulse`=0, `err_count`=0, `first_valid`=0, `first_ts`=0, `busy`=0; internal warm, consecutive and timestamp counters=0.
- States: IDLE, WARM, CHECK, FAULT.
- IDLE: `enable`=1 -> WARM, or CHECK directly if `WARMUP`=0; warm counter loaded with 0.
- WARM: warm counter increments each cycle; after `WARMUP` cycles in WARM -> CHECK. `equal` ignored.
- CHECK, per cycle with `equal` sampled:
  - The timestamp increments and saturates at all-ones. It is 0 in the first CHECK cycle.
  - `equal`=1: consecutive counter <- 0.
  - `equal`=0: `mismatch_pulse` next cycle. `err_count`+1, saturating at 2^CNT_W-1. Consecutive counter +1.
  - On the first mismatch (`first_valid`=0): `first_ts` <- current timestamp, `first_valid` <- 1.
  - If the consecutive count reaches `THRESH`: -> FAULT.
- FAULT: sticky; `enable` ignored; no sampling; all counters frozen. Only `clear` or reset leaves it.
- `enable` dropped in WARM/CHECK: -> IDLE. Consecutive, warm and timestamp counters cleared. `err_count`/`first_*` retained.
- Re-enable after IDLE restarts WARM; the timestamp restarts from 0. `first_*` keeps the earlier capture until `clear`.
- `clear`=1 in any state: next cycle IDLE, all counters, `err_count`, `first_*`, `fault` zeroed. If `enable` is still high, WARM follows one cycle later, because clear forces one IDLE cycle.
- A mismatch sampled in the same cycle as `clear` is discarded.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `enable` sampled high at edge N in IDLE. WARM covers cycles N+1..N+WARMUP. The first `equal` sample is at edge N+WARMUP+1.
- Mismatch sampled at edge M: `mismatch_pulse`, updated `err_count` and `first_*` are visible after edge M, for exactly one cycle for the pulse.
- THRESH-th consecutive mismatch sampled at edge M: `fault`=1 and `busy`=0 after edge M, in the same cycle as its `mismatch_pulse`.
- Asynchronous reset mid-operation forces reset values immediately. Release takes effect on the next rising edge.
- Counter saturation: `err_count` and the timestamp never wrap. A saturated `err_count` still pulses `mismatch_pulse`.

## Test plan
- Reset/idle: hold `rst_l`=0, then release with `enable`=0 and `equal` toggling for 20 cycles -> all outputs stay 0, `busy`=0.
- Warm-up mask: `enable`=1 at edge 10 with `equal`=0 on edges 11-13, then 1 -> `err_count`=0, no pulse, `busy`=1 from cycle 11.
- Isolated mismatches: in CHECK drive `equal`=0 at timestamps 5 and 9, 1 otherwise, `THRESH`=4 -> two single-cycle pulses, `err_count`=2, `first_ts`=5, `first_valid`=1, `fault`=0.
- Fault run: `equal`=0 for 4 consecutive CHECK cycles starting at timestamp 2 -> `fault`=1 after the 4th sample, `err_count`=4, `first_ts`=2. Then 10 more cycles of `equal`=0 and `enable` toggling -> all outputs frozen.
- Clear/restart: `clear`=1 one cycle in FAULT with `enable`=1 -> 1 cycle IDLE with all zero, then WARM for 3 cycles, then CHECK with the timestamp at 0.
- Saturation and async reset: `CNT_W`=2 with 6 isolated mismatches -> `err_count` holds at 3 while pulses continue. Assert `rst_l`=0 mid-CHECK between edges -> outputs zero before the next edge.
